// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state type, command codes and frame builder for the serial SRAM master.
package spi_mem_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_DONE} spi_state_t;
   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam int FRAME_BITS = 48;
   localparam int DATA_BITS = 16;
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic rwb, input logic [15:0] addr,
                                                         input logic [DATA_BITS-1:0] wdata);
      return {rwb ? CMD_READ : CMD_WRITE, 7'b0, addr, 1'b0, rwb ? 16'h0000 : wdata};
   endfunction
endpackage

// File: rtl/spi_mem_master_tick.sv
// spi_tick_gen: one-cycle tick every CLK_DIV clocks while enabled, counter held clear otherwise.
module spi_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(CLK_DIV + 1);
   logic [W-1:0] cnt;
   assign tick = en && cnt == W'(CLK_DIV - 1);
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) cnt <= '0;
      else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master: runs one 48-bit mode-0 SPI frame (16-bit read or write) per accepted start,
// halting the control FSM through busy_o until the DONE cycle.
module spi_mem_master
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 start_i,
   input  logic                 rwb_i,
   input  logic [15:0]          addr_i,
   input  logic [DATA_BITS-1:0] wdata_i,
   output logic [DATA_BITS-1:0] rdata_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 sclk_o,
   output logic                 mosi_o,
   input  logic                 miso_i,
   output logic                 csb_o
);
   spi_state_t state;
   logic [FRAME_BITS-1:0] frame, accept_frame;
   logic [DATA_BITS-1:0] rx;
   logic [5:0] bit_cnt;
   logic rwb, tick, active;
   assign active = state != ST_IDLE && state != ST_DONE;
   assign busy_o = (state == ST_IDLE && start_i) || active;
   assign accept_frame = build_frame(rwb_i, addr_i, wdata_i);
   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .resetb(resetb), .en(active), .tick(tick));
   // Each tick is one SCLK half-period: rising ticks sample MISO, falling ticks present the next MOSI bit.
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         state <= ST_IDLE;
         frame <= '0;
         rx <= '0;
         bit_cnt <= '0;
         rwb <= 1'b0;
         rdata_o <= '0;
         done_o <= 1'b0;
         sclk_o <= 1'b0;
         mosi_o <= 1'b0;
         csb_o <= 1'b1;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: if (start_i) begin
               state <= ST_SETUP;
               rwb <= rwb_i;
               frame <= accept_frame;
               mosi_o <= accept_frame[FRAME_BITS-1];
               csb_o <= 1'b0;
               bit_cnt <= '0;
            end
            ST_SETUP: if (tick) begin
               state <= ST_SHIFT;
               sclk_o <= 1'b1;
               rx <= {rx[DATA_BITS-2:0], miso_i};
            end
            ST_SHIFT: if (tick) begin
               sclk_o <= ~sclk_o;
               if (!sclk_o) rx <= {rx[DATA_BITS-2:0], miso_i};
               else begin
                  frame <= frame << 1;
                  mosi_o <= frame[FRAME_BITS-2];
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'(FRAME_BITS - 1)) state <= ST_HOLD;
               end
            end
            ST_HOLD: if (tick) begin
               state <= ST_DONE;
               csb_o <= 1'b1;
               done_o <= 1'b1;
               if (rwb) rdata_o <= rx;
            end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: two masters (CLK_DIV 2 and 1) against a serial SRAM model and a time-based output model.
`timescale 1ns/1ps
module tb_spi_mem_master;
   logic clk = 1'b0, resetb = 1'b0;
   logic start [2], rwb [2], sclk [2], mosi [2], miso [2], csb [2], busy [2], done [2];
   logic [15:0] addr [2], wdata [2], rdata [2];
   logic [47:0] rx_frame [2];
   logic [15:0] mem [0:65535];
   int dcnt [2];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : ch
      localparam int D = (g == 0) ? 2 : 1;
      spi_mem_master #(.CLK_DIV(D)) u_dut (
         .clk(clk), .resetb(resetb), .start_i(start[g]), .rwb_i(rwb[g]), .addr_i(addr[g]),
         .wdata_i(wdata[g]), .rdata_o(rdata[g]), .busy_o(busy[g]), .done_o(done[g]),
         .sclk_o(sclk[g]), .mosi_o(mosi[g]), .miso_i(miso[g]), .csb_o(csb[g]));
      // Output model: everything follows from the cycle offset t since the accepting edge.
      int t = 0;
      bit act = 1'b0;
      logic exp_rwb = 1'b0;
      logic [15:0] exp_addr = '0, exp_rdata = '0;
      logic [47:0] exp_frame = '0;
      always @(posedge clk or negedge resetb)
         if (!resetb) begin
            act = 1'b0;
            exp_rdata = '0;
         end else if (act) begin
            t++;
            if (t == 97 * D && exp_rwb) exp_rdata = mem[exp_addr];
            if (t > 97 * D) act = 1'b0;
         end else if (start[g]) begin
            act = 1'b1;
            t = 0;
            exp_rwb = rwb[g];
            exp_addr = addr[g];
            exp_frame = {exp_rwb ? 8'h03 : 8'h02, 7'b0, exp_addr, 1'b0, exp_rwb ? 16'h0000 : wdata[g]};
         end
      always @(negedge clk) begin
         #2;
         if (resetb) begin
            chk($sformatf("ch%0d.busy", g), busy[g], act ? t < 97 * D : start[g]);
            chk($sformatf("ch%0d.csb", g), csb[g], act ? t >= 97 * D : 1'b1);
            chk($sformatf("ch%0d.sclk", g), sclk[g], act && t < 97 * D && (t / D) % 2 == 1);
            chk($sformatf("ch%0d.done", g), done[g], act && t == 97 * D);
            chk($sformatf("ch%0d.rdata", g), rdata[g], exp_rdata);
            if (act && t < 96 * D) chk($sformatf("ch%0d.mosi", g), mosi[g], exp_frame[47 - t / (2 * D)]);
         end
      end
      // Serial SRAM model: decodes the frame from MOSI and answers reads on falling SCLK edges.
      int nb = 0;
      logic [47:0] sh = '0;
      logic [7:0] sc = '0;
      logic [15:0] sa = '0;
      always @(negedge csb[g]) begin
         nb = 0;
         sh = '0;
         sc = '0;
      end
      always @(posedge sclk[g]) if (!csb[g]) begin
         sh = {sh[46:0], mosi[g]};
         nb++;
         if (nb == 32) begin
            sc = sh[31:24];
            sa = sh[16:1];
         end
      end
      always @(negedge sclk[g]) if (!csb[g])
         miso[g] = (sc == 8'h03 && nb >= 32 && nb < 48) ? mem[sa][47 - nb] : 1'b1;
      always @(posedge csb[g]) begin
         rx_frame[g] = sh;
         if (nb == 48 && sh[47:40] == 8'h02) mem[sh[32:17]] = sh[15:0];
      end
      always @(posedge clk) if (done[g]) dcnt[g]++;
   end

   task automatic wait_done(input int g, output int lat, output int hi);
      lat = 0;
      hi = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         lat++;
         start[g] = 1'b0;
         if (sclk[g]) hi++;
         if (done[g]) return;
      end
      tests++;
      fails++;
      $display("FAIL ch%0d.done_timeout: no done_o after %0d cycles, required within 400", g, lat);
   endtask

   task automatic xfer(input int g, input logic r, input logic [15:0] a, input logic [15:0] w,
                       output int lat, output int hi);
      @(negedge clk);
      start[g] = 1'b1;
      rwb[g] = r;
      addr[g] = a;
      wdata[g] = w;
      wait_done(g, lat, hi);
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, hi, nbusy, nfree, d0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[1] = 16'hA55A;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         rwb[i] = 1'b0;
         addr[i] = '0;
         wdata[i] = '0;
         miso[i] = 1'b1;
         dcnt[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset.csb", csb[0], 1'b1);
      chk("reset.sclk", sclk[0], 1'b0);
      chk("reset.mosi", mosi[0], 1'b0);
      chk("reset.done", done[0], 1'b0);
      chk("reset.rdata", rdata[0], 16'h0000);
      chk("reset.busy", busy[0], 1'b0);
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      // Write 0xBEEF to word 0x1234.
      xfer(0, 1'b0, 16'h1234, 16'hBEEF, lat, hi);
      chk("write.latency", lat, 195);
      chk("write.frame", rx_frame[0], 48'h02_002468_BEEF);
      chk("write.mem", mem[16'h1234], 16'hBEEF);
      chk("write.rdata", rdata[0], 16'h0000);
      // Read word 0x0001.
      xfer(0, 1'b1, 16'h0001, 16'hFFFF, lat, hi);
      chk("read.latency", lat, 195);
      chk("read.frame", rx_frame[0], 48'h03_000002_0000);
      chk("read.rdata", rdata[0], 16'hA55A);
      xfer(0, 1'b0, 16'h0010, 16'h0F0F, lat, hi);
      chk("write2.rdata_kept", rdata[0], 16'hA55A);
      // Halt: start held like a stalled FSM, released only after the DONE cycle is seen.
      @(negedge clk);
      start[0] = 1'b1;
      rwb[0] = 1'b1;
      addr[0] = 16'h1234;
      #1;
      chk("halt.same_cycle", busy[0], 1'b1);
      nbusy = 1;
      nfree = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy[0]) nbusy++;
         else nfree++;
         if (done[0]) break;
      end
      start[0] = 1'b0;
      chk("halt.busy_cycles", nbusy, 195);
      chk("halt.fsm_advances", nfree, 1);
      chk("halt.rdata", rdata[0], 16'hBEEF);
      repeat (3) @(negedge clk);
      // Back-to-back read then write, start held across DONE.
      start[0] = 1'b1;
      rwb[0] = 1'b1;
      addr[0] = 16'h0001;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done[0]) break;
      end
      chk("b2b.frame1", rx_frame[0], 48'h03_000002_0000);
      chk("b2b.rdata1", rdata[0], 16'hA55A);
      rwb[0] = 1'b0;
      addr[0] = 16'h0042;
      wdata[0] = 16'h1357;
      hi = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!csb[0]) break;
         hi++;
      end
      start[0] = 1'b0;
      chk("b2b.csb_high", hi, 2);
      wait_done(0, lat, hi);
      chk("b2b.latency2", lat, 194);
      chk("b2b.frame2", rx_frame[0], 48'h02_000084_1357);
      chk("b2b.mem", mem[16'h0042], 16'h1357);
      chk("b2b.rdata_kept", rdata[0], 16'hA55A);
      // Reset in the middle of a read.
      @(negedge clk);
      start[0] = 1'b1;
      rwb[0] = 1'b1;
      addr[0] = 16'h0001;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (ch[0].nb >= 20) break;
      end
      d0 = dcnt[0];
      resetb = 1'b0;
      #1;
      chk("midreset.csb", csb[0], 1'b1);
      chk("midreset.sclk", sclk[0], 1'b0);
      chk("midreset.rdata", rdata[0], 16'h0000);
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset.no_done", dcnt[0], d0);
      xfer(0, 1'b1, 16'h1234, 16'h0000, lat, hi);
      chk("midreset.read_latency", lat, 195);
      chk("midreset.read_rdata", rdata[0], 16'hBEEF);
      // CLK_DIV=1 instance.
      xfer(1, 1'b1, 16'h0001, 16'h0000, lat, hi);
      chk("div1.latency", lat, 98);
      chk("div1.sclk_high", hi, 48);
      chk("div1.rdata", rdata[1], 16'hA55A);
      chk("div1.frame", rx_frame[1], 48'h03_000002_0000);
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
